rvvi_host_ack_parser: RTL and testbench

//  Receive-side parser between the ethernet MAC RX AXI-stream (32-bit) and the RVVI active list.

---
 rtl/rvvi_pkg.sv | 31 +++
 rtl/rvvi_satcounter.sv | 31 +++
 rtl/rvvi_host_ack_parser.sv | 176 +++++++++++++++++
 tb/tb_rvvi_host_ack_parser.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_pkg.sv
// Shared RVVI constants, word indices and parser state type.
package rvvi_pkg;

    localparam logic [15:0] RVVI_ETH_TYPE = 16'h005c;
    localparam logic [15:0] RVVI_ACK_TAG  = 16'h6b61;
    localparam int unsigned RVVI_WORD_W   = 32;

    localparam logic [1:0] W_DST_LO   = 2'd0;
    localparam logic [1:0] W_MAC_MIX  = 2'd1;
    localparam logic [1:0] W_SRC_HI   = 2'd2;
    localparam logic [1:0] W_TYPE_TAG = 2'd3;

    typedef enum logic [2:0] {HDR, MINST, DELAY, TAIL, DRAIN} ackstate_t;

    // Expected 32-bit header word for a given header word index.
    function automatic logic [31:0] hdr_word(input logic [1:0]  idx,
                                             input logic [47:0] dst,
                                             input logic [47:0] src,
                                             input logic [15:0] tag,
                                             input logic [15:0] etype);
        logic [31:0] w;
        case (idx)
            W_DST_LO:  w = dst[31:0];
            W_MAC_MIX: w = {src[15:0], dst[47:32]};
            W_SRC_HI:  w = src[47:16];
            default:   w = {tag, etype};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rvvi_satcounter.sv
// Saturating up-counter with synchronous increment and async active-high reset.
module rvvi_satcounter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rvvi_host_ack_parser.sv
// Host-ack frame parser on the MAC RX stream: filters by MAC/ethertype/tag and
// extracts minstret and inter-packet delay. Frame statistics under RVVI_ACK_STATS_EN.
module rvvi_host_ack_parser
    import rvvi_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter logic [15:0] ETH_TYPE = RVVI_ETH_TYPE,
    parameter logic [15:0] ACK_TAG  = RVVI_ACK_TAG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     RxAxiTdata,
    input  logic [3:0]      RxAxiTkeep,
    input  logic            RxAxiTvalid,
    input  logic            RxAxiTlast,
    input  logic            RxAxiTuser,
    output logic            RxAxiTready,
    input  logic [47:0]     LocalMac,
    input  logic [47:0]     RemoteMac,
    output logic            Valid,
    output logic [XLEN-1:0] Minstr,
    output logic [31:0]     InterPacketDelay,
    output logic [15:0]     GoodCount,
    output logic [15:0]     DropCount
);

    localparam int unsigned MW  = XLEN / RVVI_WORD_W;
    localparam int unsigned CW  = 2;
    localparam int unsigned MIW = (MW > 1) ? $clog2(MW) : 1;

    ackstate_t                     state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [MW-1:0][RVVI_WORD_W-1:0] minst_sh_q, minst_sh_d;
    logic [31:0]                   delay_sh_q, delay_sh_d;
    logic [XLEN-1:0]               minstr_q, minstr_d;
    logic [31:0]                   ipd_q, ipd_d;
    logic                          valid_q, valid_d;
    logic                          ready_q, ready_d;

    logic        beat;
    logic        full;
    logic        good_fin;
    logic [31:0] hdr_exp;

    assign beat    = RxAxiTvalid & ready_q;
    assign full    = (RxAxiTkeep == 4'hF);
    assign hdr_exp = hdr_word(cnt_q, LocalMac, RemoteMac, ACK_TAG, ETH_TYPE);

    // Next-state, capture and finish logic; every tlast beat ends a frame.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        minst_sh_d = minst_sh_q;
        delay_sh_d = delay_sh_q;
        minstr_d   = minstr_q;
        ipd_d      = ipd_q;
        good_fin   = 1'b0;
        ready_d    = 1'b1;

        if (beat) begin
            unique case (state_q)
                HDR: begin
                    if (RxAxiTlast) begin
                        state_d = HDR;
                        cnt_d   = '0;
                    end else if (!full || (RxAxiTdata != hdr_exp)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else if (cnt_q == W_TYPE_TAG) begin
                        state_d = MINST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CW'(cnt_q + CW'(1));
                    end
                end
                MINST: begin
                    minst_sh_d[cnt_q[MIW-1:0]] = RxAxiTdata;
                    if (RxAxiTlast) begin
                        state_d = HDR;
                        cnt_d   = '0;
                    end else if (!full) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(MW - 1)) begin
                        state_d = DELAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = CW'(cnt_q + CW'(1));
                    end
                end
                DELAY: begin
                    delay_sh_d = RxAxiTdata;
                    if (RxAxiTlast) begin
                        state_d  = HDR;
                        good_fin = full & ~RxAxiTuser;
                    end else if (!full) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = TAIL;
                    end
                end
                TAIL: begin
                    if (RxAxiTlast) begin
                        state_d  = HDR;
                        good_fin = ~RxAxiTuser;
                    end
                end
                DRAIN: begin
                    if (RxAxiTlast) begin
                        state_d = HDR;
                    end
                end
                default: begin
                    state_d = HDR;
                    cnt_d   = '0;
                end
            endcase
        end

        if (good_fin) begin
            minstr_d = minst_sh_q;
            ipd_d    = delay_sh_d;
        end
        valid_d = good_fin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HDR;
            cnt_q      <= '0;
            minst_sh_q <= '0;
            delay_sh_q <= '0;
            minstr_q   <= '0;
            ipd_q      <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            minst_sh_q <= minst_sh_d;
            delay_sh_q <= delay_sh_d;
            minstr_q   <= minstr_d;
            ipd_q      <= ipd_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign RxAxiTready      = ready_q;
    assign Valid            = valid_q;
    assign Minstr           = minstr_q;
    assign InterPacketDelay = ipd_q;

`ifdef RVVI_ACK_STATS_EN
    logic drop_fin;
    assign drop_fin = beat & RxAxiTlast & ~good_fin;

    rvvi_satcounter #(.WIDTH(16)) u_good_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (good_fin),
        .count (GoodCount)
    );

    rvvi_satcounter #(.WIDTH(16)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_fin),
        .count (DropCount)
    );
`else
    assign GoodCount = '0;
    assign DropCount = '0;
`endif

endmodule

// File: tb/tb_rvvi_host_ack_parser.sv
// Bench for rvvi_host_ack_parser: vector table plus hand-written multi-cycle sequences.
module tb_rvvi_host_ack_parser;

`ifdef RVVI_ACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] RxAxiTdata;
    logic [3:0]  RxAxiTkeep;
    logic        RxAxiTvalid;
    logic        RxAxiTlast;
    logic        RxAxiTuser;
    logic        RxAxiTready;
    logic [47:0] LocalMac;
    logic [47:0] RemoteMac;
    logic        Valid;
    logic [63:0] Minstr;
    logic [31:0] InterPacketDelay;
    logic [15:0] GoodCount;
    logic [15:0] DropCount;

    rvvi_host_ack_parser #(.XLEN(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .RxAxiTdata       (RxAxiTdata),
        .RxAxiTkeep       (RxAxiTkeep),
        .RxAxiTvalid      (RxAxiTvalid),
        .RxAxiTlast       (RxAxiTlast),
        .RxAxiTuser       (RxAxiTuser),
        .RxAxiTready      (RxAxiTready),
        .LocalMac         (LocalMac),
        .RemoteMac        (RemoteMac),
        .Valid            (Valid),
        .Minstr           (Minstr),
        .InterPacketDelay (InterPacketDelay),
        .GoodCount        (GoodCount),
        .DropCount        (DropCount)
    );

    typedef struct {
        logic [15:0] etype;
        logic [15:0] tag;
        logic        bad_mac;
        logic [63:0] minstr;
        logic [31:0] dly;
        logic        tuser;
        int          extra;
        int          trunc;
        int          pkeep;
        int          gap;
        logic        exp_good;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [63:0] m;
        logic [31:0] d;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        exp_q[$];
    logic [31:0] fw[$];
    logic [3:0]  fk[$];
    logic [63:0] mdl_m;
    logic [31:0] mdl_d;
    int          exp_gc;
    int          exp_dc;
    vec_t        vt[13];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: each Valid pulse must match the oldest pending good frame.
    always @(negedge clk) begin
        if (!reset) begin
            if (Valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 64'(Valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("valid_cycle", 64'(cyc), 64'(e.cyc));
                    check("valid_minstr", Minstr, e.m);
                    check("valid_delay", 64'(InterPacketDelay), 64'(e.d));
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                check("valid_missing", 64'(Valid), 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic build(input vec_t v);
        logic [47:0] dst;
        logic [47:0] src;
        dst = v.bad_mac ? (LocalMac ^ 48'h0000_0000_0100) : LocalMac;
        src = RemoteMac;
        fw.delete();
        fk.delete();
        fw.push_back(dst[31:0]);
        fw.push_back({src[15:0], dst[47:32]});
        fw.push_back(src[47:16]);
        fw.push_back({v.tag, v.etype});
        fw.push_back(v.minstr[31:0]);
        fw.push_back(v.minstr[63:32]);
        fw.push_back(v.dly);
        for (int i = 0; i < v.extra; i++) fw.push_back($urandom);
        if (v.trunc > 0) begin
            while (fw.size() > v.trunc) void'(fw.pop_back());
        end
        for (int i = 0; i < fw.size(); i++) fk.push_back((i == v.pkeep) ? 4'h7 : 4'hF);
    endtask

    task automatic drive(input int first, input int stop, input logic do_last, input logic tuser,
                         input int gap, input logic exp_good, input logic [63:0] m, input logic [31:0] d);
        for (int i = first; i < stop; i++) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                RxAxiTvalid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            RxAxiTvalid = 1'b1;
            RxAxiTdata  = fw[i];
            RxAxiTkeep  = fk[i];
            RxAxiTlast  = do_last && (i == stop - 1);
            RxAxiTuser  = RxAxiTlast ? tuser : 1'b0;
            if (RxAxiTlast) begin
                if (exp_good) begin
                    exp_q.push_back('{cyc + 1, m, d});
                    mdl_m = m;
                    mdl_d = d;
                    exp_gc++;
                end else begin
                    exp_dc++;
                end
            end
            @(posedge clk);
            #1;
        end
        RxAxiTvalid = 1'b0;
        RxAxiTlast  = 1'b0;
        RxAxiTuser  = 1'b0;
        RxAxiTkeep  = 4'h0;
    endtask

    task automatic settle_and_check(input string tag);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_minstr"}, Minstr, mdl_m);
        check({tag, "_delay"}, 64'(InterPacketDelay), 64'(mdl_d));
        check({tag, "_goodcnt"}, 64'(GoodCount), STATS ? 64'(exp_gc) : 64'd0);
        check({tag, "_dropcnt"}, 64'(DropCount), STATS ? 64'(exp_dc) : 64'd0);
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        RxAxiTvalid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 64'(RxAxiTready), 64'd0);
        check("rst_valid", 64'(Valid), 64'd0);
        check("rst_minstr", Minstr, 64'd0);
        check("rst_delay", 64'(InterPacketDelay), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mdl_m = '0;
        mdl_d = '0;
        exp_gc = 0;
        exp_dc = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_ready_after", 64'(RxAxiTready), 64'd1);
        check("rst_goodcnt", 64'(GoodCount), 64'd0);
        check("rst_dropcnt", 64'(DropCount), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset       = 1'b1;
        RxAxiTdata  = '0;
        RxAxiTkeep  = '0;
        RxAxiTvalid = 1'b0;
        RxAxiTlast  = 1'b0;
        RxAxiTuser  = 1'b0;
        LocalMac    = 48'h0A1B_2C3D_4E5F;
        RemoteMac   = 48'h1122_3344_5566;
        mdl_m  = '0;
        mdl_d  = '0;
        exp_gc = 0;
        exp_dc = 0;

        //          etype     tag       badmac minstr                  dly           tuser extra trunc pkeep gap good
        vt[0]  = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0001_0000_00A5, 32'd40,       1'b0, 0, 0, -1,  0, 1'b1};
        vt[1]  = '{16'h0800, 16'h6b61, 1'b0, 64'h0000_0001_0000_00A5, 32'd40,       1'b0, 0, 0, -1,  0, 1'b0};
        vt[2]  = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0001_0000_00A5, 32'd41,       1'b1, 0, 0, -1,  0, 1'b0};
        vt[3]  = '{16'h005c, 16'h6b61, 1'b1, 64'h0000_0000_0000_0007, 32'd3,        1'b0, 0, 0, -1,  0, 1'b0};
        vt[4]  = '{16'h005c, 16'h6b62, 1'b0, 64'h0000_0000_0000_0008, 32'd4,        1'b0, 0, 0, -1,  0, 1'b0};
        vt[5]  = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0000_0000_0009, 32'd5,        1'b0, 0, 6, -1,  0, 1'b0};
        vt[6]  = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0000_0000_000A, 32'd6,        1'b0, 0, 3, -1,  0, 1'b0};
        vt[7]  = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0000_0000_000B, 32'd7,        1'b0, 0, 0,  5,  0, 1'b0};
        vt[8]  = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0000_0000_000C, 32'd8,        1'b0, 0, 0,  6,  0, 1'b0};
        vt[9]  = '{16'h005c, 16'h6b61, 1'b0, 64'hDEAD_BEEF_0123_4567, 32'd77,       1'b0, 3, 0, -1, 40, 1'b1};
        vt[10] = '{16'h005c, 16'h6b61, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 0,  8,  0, 1'b1};
        vt[11] = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0000_0000_000D, 32'd9,        1'b1, 2, 0, -1,  0, 1'b0};
        vt[12] = '{16'h005c, 16'h6b61, 1'b0, 64'h0000_0000_0000_000E, 32'd10,       1'b0, 0, 0,  0,  0, 1'b0};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            v = vt[i];
            build(v);
            drive(0, fw.size(), 1'b1, v.tuser, v.gap, v.exp_good, v.minstr, v.dly);
            settle_and_check($sformatf("vec%0d", i));
        end

        // Back-to-back good frames, no idle cycle between them.
        v = vt[0];
        v.dly = 32'd5;
        v.minstr = 64'h0000_0000_0000_1234;
        build(v);
        drive(0, fw.size(), 1'b1, 1'b0, 0, 1'b1, v.minstr, v.dly);
        v.dly = 32'd9;
        v.minstr = 64'h0000_0002_0000_5678;
        build(v);
        drive(0, fw.size(), 1'b1, 1'b0, 0, 1'b1, v.minstr, v.dly);
        settle_and_check("b2b");

        // Reset after W4 of a good frame; the remnant must be dropped.
        v = vt[0];
        v.dly = 32'd55;
        build(v);
        drive(0, 5, 1'b0, 1'b0, 0, 1'b0, v.minstr, v.dly);
        do_reset();
        drive(5, fw.size(), 1'b1, 1'b0, 0, 1'b0, v.minstr, v.dly);
        settle_and_check("rst_remnant");

        v = vt[0];
        v.dly = 32'd66;
        v.minstr = 64'h0000_0003_0000_0042;
        build(v);
        drive(0, fw.size(), 1'b1, 1'b0, 20, 1'b1, v.minstr, v.dly);
        settle_and_check("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
